// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the cache-to-byte-RAM memory controller.
package mem_ctrl_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned MASK_W         = 4;

  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef struct packed {
    logic              rd;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } req_t;

endpackage

// File: rtl/mem_req_slot.sv
// One-deep request latch for a cache port; frees itself on that port's done pulse.
module mem_req_slot
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        rw_flag,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] write_data,
  input  logic [MASK_W-1:0] write_mask,
  input  logic              clr,
  output logic              pend_c,
  output logic              pend_rd_c,
  output logic              valid_nxt_c,
  output req_t              req
);

  req_t req_q, req_d;
  logic valid_q, valid_d;
  logic flag_any, flag_rd, load;

  always_comb begin
    flag_any = (rw_flag & (RW_READ | RW_WRITE)) != 2'b00;
    flag_rd  = (rw_flag & RW_READ) != 2'b00;
    load     = flag_any && (!valid_q || clr);
    valid_d  = valid_q;
    req_d    = req_q;
    if (load) begin
      valid_d    = 1'b1;
      req_d.rd   = flag_rd;
      req_d.addr = addr;
      req_d.data = write_data;
      req_d.mask = write_mask;
    end else if (clr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  // An empty slot presents the incoming pulse directly; a completing slot is not eligible.
  assign pend_c      = valid_q ? !clr : flag_any;
  assign pend_rd_c   = valid_q ? req_q.rd : flag_rd;
  assign valid_nxt_c = valid_d;
  assign req         = req_q;

endmodule

// File: rtl/mem_ctrl.sv
// Two-port round-robin controller serialising word requests onto a byte-wide synchronous RAM.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BIT = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              rw_flag_0,
  input  logic [1:0]              rw_flag_1,
  input  logic [31:0]             addr_0,
  input  logic [31:0]             addr_1,
  input  logic [31:0]             write_data_0,
  input  logic [31:0]             write_data_1,
  input  logic [3:0]              write_mask_0,
  input  logic [3:0]              write_mask_1,
  output logic [31:0]             read_data_0,
  output logic [31:0]             read_data_1,
  output logic                    busy_0,
  output logic                    busy_1,
  output logic                    done_0,
  output logic                    done_1,
  output logic [RAM_ADDR_BIT-1:0] ram_addr,
  output logic [7:0]              ram_din,
  output logic                    ram_we,
  input  logic [7:0]              ram_dout
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic        last_grant_q, last_grant_d;
  logic [23:0] rbuf_q, rbuf_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        busy0_q, busy0_d, busy1_q, busy1_d;
  logic        grant;

  logic pend0, pend1, pend_rd0, pend_rd1, vnxt0, vnxt1;
  req_t req0, req1, cur;
  logic active;
  logic unused_addr_bits;

  mem_req_slot u_slot0 (
    .clk(clk), .rst(rst), .rw_flag(rw_flag_0), .addr(addr_0),
    .write_data(write_data_0), .write_mask(write_mask_0), .clr(done0_q),
    .pend_c(pend0), .pend_rd_c(pend_rd0), .valid_nxt_c(vnxt0), .req(req0)
  );

  mem_req_slot u_slot1 (
    .clk(clk), .rst(rst), .rw_flag(rw_flag_1), .addr(addr_1),
    .write_data(write_data_1), .write_mask(write_mask_1), .clr(done1_q),
    .pend_c(pend1), .pend_rd_c(pend_rd1), .valid_nxt_c(vnxt1), .req(req1)
  );

  assign cur = sel_q ? req1 : req0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    rbuf_d       = rbuf_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    grant        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend0 || pend1) begin
          grant        = (pend0 && pend1) ? !last_grant_q : pend1;
          sel_d        = grant;
          last_grant_d = grant;
          cnt_d        = 3'd0;
          state_d      = (grant ? pend_rd1 : pend_rd0) ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + 3'd1;
        // RAM data trails the address by one cycle, so byte k arrives at cnt k+1.
        case (cnt_q)
          3'd1:    rbuf_d[7:0]   = ram_dout;
          3'd2:    rbuf_d[15:8]  = ram_dout;
          3'd3:    rbuf_d[23:16] = ram_dout;
          default: ;
        endcase
        if (cnt_q == 3'(BYTES_PER_WORD)) begin
          if (sel_q) rdata1_d = {ram_dout, rbuf_q};
          else       rdata0_d = {ram_dout, rbuf_q};
          done0_d = !sel_q;
          done1_d = sel_q;
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(BYTES_PER_WORD - 1)) begin
          done0_d = !sel_q;
          done1_d = sel_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy0_d = vnxt0 && !done0_d;
    busy1_d = vnxt1 && !done1_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rbuf_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy0_q      <= 1'b0;
      busy1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      rbuf_q       <= rbuf_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy0_q      <= busy0_d;
      busy1_q      <= busy1_d;
    end
  end

  // RAM side is decoded from registered state; reset blanks it immediately.
  always_comb begin
    active   = !rst && (state_q != ST_IDLE) && (cnt_q < 3'(BYTES_PER_WORD));
    ram_addr = '0;
    ram_din  = 8'h00;
    ram_we   = 1'b0;
    if (active) begin
      ram_addr = {cur.addr[RAM_ADDR_BIT-1:2], cnt_q[1:0]};
      if (state_q == ST_WRITE) begin
        ram_din = 8'(cur.data >> {cnt_q[1:0], 3'b000});
        ram_we  = cur.mask[cnt_q[1:0]];
      end
    end
  end

  assign unused_addr_bits = ^{cur.addr[31:RAM_ADDR_BIT], cur.addr[1:0]};

  assign read_data_0 = rdata0_q;
  assign read_data_1 = rdata1_q;
  assign done_0      = done0_q;
  assign done_1      = done1_q;
  assign busy_0      = busy0_q;
  assign busy_1      = busy1_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural byte-wide synchronous RAM.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  rw_flag_0, rw_flag_1;
  logic [31:0] addr_0, addr_1, write_data_0, write_data_1;
  logic [3:0]  write_mask_0, write_mask_1;
  logic [31:0] read_data_0, read_data_1;
  logic        busy_0, busy_1, done_0, done_1;
  logic [16:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  logic [7:0]  mem [0:131071] = '{default: 8'h00};
  logic        preload_req;

  int total = 0;
  int bad   = 0;

  mem_ctrl #(.RAM_ADDR_BIT(17)) dut (
    .clk(clk), .rst(rst),
    .rw_flag_0(rw_flag_0), .rw_flag_1(rw_flag_1),
    .addr_0(addr_0), .addr_1(addr_1),
    .write_data_0(write_data_0), .write_data_1(write_data_1),
    .write_mask_0(write_mask_0), .write_mask_1(write_mask_1),
    .read_data_0(read_data_0), .read_data_1(read_data_1),
    .busy_0(busy_0), .busy_1(busy_1), .done_0(done_0), .done_1(done_1),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (preload_req) begin
      mem[17'h100] = 8'h11; mem[17'h101] = 8'h22; mem[17'h102] = 8'h33; mem[17'h103] = 8'h44;
      mem[17'h204] = 8'h01; mem[17'h205] = 8'h02; mem[17'h206] = 8'h03; mem[17'h207] = 8'h04;
    end else if (ram_we) begin
      mem[ram_addr] = ram_din;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    rw_flag_0 = 2'b00;
    rw_flag_1 = 2'b00;
  endtask

  task automatic send(input int p, input logic [1:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m);
    if (p == 0) begin
      rw_flag_0 = f; addr_0 = a; write_data_0 = d; write_mask_0 = m;
    end else begin
      rw_flag_1 = f; addr_1 = a; write_data_1 = d; write_mask_1 = m;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_flags();
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  // Lone transaction from an idle controller, checked cycle by cycle.
  task automatic txn(input int p, input logic [1:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp_rd);
    int   lat;
    logic rd;
    rd  = f[0];
    lat = rd ? 6 : 5;
    cyc();
    send(p, f, a, d, m);
    for (int i = 1; i <= lat; i++) begin
      cyc();
      if (i == 1) clear_flags();
      check_eq($sformatf("p%0d done c%0d", p, i), 32'(p != 0 ? done_1 : done_0), 32'(i == lat));
      check_eq($sformatf("p%0d busy c%0d", p, i), 32'(p != 0 ? busy_1 : busy_0), 32'(i != lat));
      if (i <= 4) begin
        check_eq($sformatf("p%0d ram_addr c%0d", p, i), 32'(ram_addr), (a & 32'h1FFFC) + 32'(i - 1));
        check_eq($sformatf("p%0d ram_we c%0d", p, i), 32'(ram_we), rd ? 32'd0 : 32'(m[i-1]));
        if (!rd) check_eq($sformatf("p%0d ram_din c%0d", p, i), 32'(ram_din), 32'(d[8*(i-1) +: 8]));
      end
    end
    if (rd) check_eq($sformatf("p%0d read_data", p), p != 0 ? read_data_1 : read_data_0, exp_rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    preload_req = 1'b1;
    clear_flags();
    addr_0 = '0; addr_1 = '0; write_data_0 = '0; write_data_1 = '0;
    write_mask_0 = '0; write_mask_1 = '0;
    do_reset();
    preload_req = 1'b0;

    check_eq("rst read_data_0", read_data_0, 32'h0);
    check_eq("rst read_data_1", read_data_1, 32'h0);
    check_eq("rst done", {30'd0, done_1, done_0}, 32'h0);
    check_eq("rst busy", {30'd0, busy_1, busy_0}, 32'h0);
    check_eq("rst ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rst ram_din", 32'(ram_din), 32'h0);
    check_eq("rst ram_we", 32'(ram_we), 32'h0);

    // Single read, masked write, read-back of the partially written word.
    txn(0, 2'b01, 32'h100, 32'h0, 4'h0, 32'h44332211);
    txn(1, 2'b10, 32'h204, 32'hAABBCCDD, 4'b0101, 32'h0);
    check_eq("mw 204", 32'(mem[17'h204]), 32'hDD);
    check_eq("mw 205", 32'(mem[17'h205]), 32'h02);
    check_eq("mw 206", 32'(mem[17'h206]), 32'hBB);
    check_eq("mw 207", 32'(mem[17'h207]), 32'h04);
    check_eq("mw rdata1 kept", read_data_1, 32'h0);
    txn(1, 2'b01, 32'h204, 32'h0, 4'h0, 32'h04BB02DD);

    // Tie right after reset: port 0 first, port 1 starts the cycle after done_0.
    do_reset();
    send(0, 2'b01, 32'h100, 32'h0, 4'h0);
    send(1, 2'b01, 32'h204, 32'h0, 4'h0);
    cyc(); clear_flags();
    check_eq("tie1 first addr", 32'(ram_addr), 32'h100);
    check_eq("tie1 busy_1 waiting", 32'(busy_1), 32'h1);
    repeat (5) cyc();
    check_eq("tie1 done_0", 32'(done_0), 32'h1);
    check_eq("tie1 done_1 early", 32'(done_1), 32'h0);
    check_eq("tie1 rdata0", read_data_0, 32'h44332211);
    cyc();
    check_eq("tie1 second addr", 32'(ram_addr), 32'h204);
    repeat (5) cyc();
    check_eq("tie1 done_1", 32'(done_1), 32'h1);
    check_eq("tie1 rdata1", read_data_1, 32'h04BB02DD);

    // Lone port 0 read, then a tie: port 1 is now first.
    txn(0, 2'b01, 32'h100, 32'h0, 4'h0, 32'h44332211);
    cyc();
    send(0, 2'b01, 32'h204, 32'h0, 4'h0);
    send(1, 2'b01, 32'h100, 32'h0, 4'h0);
    cyc(); clear_flags();
    check_eq("tie2 first addr", 32'(ram_addr), 32'h100);
    repeat (5) cyc();
    check_eq("tie2 done_1", 32'(done_1), 32'h1);
    check_eq("tie2 done_0 early", 32'(done_0), 32'h0);
    check_eq("tie2 rdata1", read_data_1, 32'h44332211);
    repeat (6) cyc();
    check_eq("tie2 done_0", 32'(done_0), 32'h1);
    check_eq("tie2 rdata0", read_data_0, 32'h04BB02DD);

    // Back-to-back: new port 0 read issued in the done_0 cycle.
    cyc();
    send(0, 2'b01, 32'h100, 32'h0, 4'h0);
    cyc(); clear_flags();
    repeat (5) cyc();
    check_eq("b2b done_0 first", 32'(done_0), 32'h1);
    send(0, 2'b01, 32'h204, 32'h0, 4'h0);
    cyc(); clear_flags();
    check_eq("b2b busy_0 captured", 32'(busy_0), 32'h1);
    check_eq("b2b idle gap addr", 32'(ram_addr), 32'h0);
    check_eq("b2b done_0 low", 32'(done_0), 32'h0);
    cyc();
    check_eq("b2b first byte addr", 32'(ram_addr), 32'h204);
    repeat (4) cyc();
    check_eq("b2b done_0 not yet", 32'(done_0), 32'h0);
    cyc();
    check_eq("b2b done_0 second", 32'(done_0), 32'h1);
    check_eq("b2b rdata0", read_data_0, 32'h04BB02DD);

    // Port 1 write queued behind a port 0 read.
    cyc();
    send(0, 2'b01, 32'h100, 32'h0, 4'h0);
    cyc(); clear_flags();
    cyc();
    send(1, 2'b10, 32'h300, 32'h12345678, 4'hF);
    cyc(); clear_flags();
    check_eq("q busy_1", 32'(busy_1), 32'h1);
    repeat (3) cyc();
    check_eq("q done_0", 32'(done_0), 32'h1);
    cyc();
    check_eq("q wr addr", 32'(ram_addr), 32'h300);
    check_eq("q wr we", 32'(ram_we), 32'h1);
    check_eq("q wr din", 32'(ram_din), 32'h78);
    repeat (4) cyc();
    check_eq("q done_1", 32'(done_1), 32'h1);
    check_eq("q mem 303", 32'(mem[17'h303]), 32'h12);
    txn(1, 2'b01, 32'h300, 32'h0, 4'h0, 32'h12345678);

    // Both flag bits set reads; upper address bits wrap away.
    txn(1, 2'b11, 32'hFFFE_0101, 32'hDEADBEEF, 4'hF, 32'h44332211);
    // Mask 0000 still takes four cycles and completes.
    txn(0, 2'b10, 32'h100, 32'hDEADBEEF, 4'h0, 32'h0);
    check_eq("m0 mem 100", 32'(mem[17'h100]), 32'h11);

    // Reset during cnt=2 of a write.
    cyc();
    send(0, 2'b10, 32'h400, 32'hCAFEF00D, 4'hF);
    cyc(); clear_flags();
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check_eq("rw ram_we in rst", 32'(ram_we), 32'h0);
    cyc();
    rst = 1'b0;
    check_eq("rw busy_0", 32'(busy_0), 32'h0);
    check_eq("rw ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rw ram_din", 32'(ram_din), 32'h0);
    check_eq("rw read_data_0", read_data_0, 32'h0);
    check_eq("rw read_data_1", read_data_1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("rw no done c%0d", i), {30'd0, done_1, done_0}, 32'h0);
      cyc();
    end
    check_eq("rw mem 401", 32'(mem[17'h401]), 32'hF0);
    check_eq("rw mem 402", 32'(mem[17'h402]), 32'h00);
    txn(0, 2'b01, 32'h400, 32'h0, 4'h0, 32'h0000F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
